result_tx_interface: RTL

//   Output-side counterpart of the UART operand-capture interface: takes the ALU result and
//   its flags and serialises them as UART TX byte frames (result byte, then optional flags byte).

---
 rtl/result_tx_interface.sv | 97 +++++++++
 1 files changed

// File: rtl/result_tx_interface.sv
// Serialises an ALU result (and optionally its flags) into UART TX byte frames.
// The uart_tx core is driven with one-cycle start pulses and paced by its done flag.
module result_tx_interface #(
  parameter int NB_DATA    = 8,
  parameter int NB_FLAGS   = 3,
  parameter int SEND_FLAGS = 1
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic [NB_DATA-1:0]  i_result,
  input  logic [NB_FLAGS-1:0] i_flags,
  input  logic                i_result_valid,
  input  logic                i_tx_done,
  output logic [NB_DATA-1:0]  o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy,
  output logic                o_drop,
  output logic [2:0]          o_leds
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_RES = 3'd1;
  localparam logic [2:0] S_WAIT_RES = 3'd2;
  localparam logic [2:0] S_LOAD_FLG = 3'd3;
  localparam logic [2:0] S_WAIT_FLG = 3'd4;

  logic [2:0]          state;
  logic [2:0]          next_state;
  logic                valid_prev;
  logic                done_prev;
  logic                valid_edge;
  logic                done_edge;
  logic [NB_FLAGS-1:0] flg_q;
  logic [NB_DATA-1:0]  flags_byte;

  assign valid_edge = i_result_valid & ~valid_prev;
  assign done_edge  = i_tx_done & ~done_prev;

  always_comb begin
    flags_byte                 = '0;
    flags_byte[NB_FLAGS-1:0]   = flg_q;
  end

  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:     next_state = valid_edge ? S_LOAD_RES : S_IDLE;
      S_LOAD_RES: next_state = S_WAIT_RES;
      S_WAIT_RES: begin
        if (done_edge) next_state = (SEND_FLAGS != 0) ? S_LOAD_FLG : S_IDLE;
        else           next_state = S_WAIT_RES;
      end
      S_LOAD_FLG: next_state = S_WAIT_FLG;
      S_WAIT_FLG: next_state = done_edge ? S_IDLE : S_WAIT_FLG;
      default:    next_state = S_IDLE;
    endcase
  end

  function automatic logic [2:0] leds_for(input logic [2:0] s);
    case (s)
      S_LOAD_RES, S_WAIT_RES: leds_for = 3'b010;
      S_LOAD_FLG, S_WAIT_FLG: leds_for = 3'b100;
      default:                leds_for = 3'b001;
    endcase
  endfunction

  // Outputs are registered from next_state so they line up with the state register;
  // tx_data is loaded together with the start pulse so the byte is valid when uart_tx samples it.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      valid_prev <= 1'b0;
      done_prev  <= 1'b0;
      flg_q      <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_drop     <= 1'b0;
      o_leds     <= 3'b001;
    end else begin
      state      <= next_state;
      valid_prev <= i_result_valid;
      done_prev  <= i_tx_done;
      o_tx_start <= (next_state == S_LOAD_RES) || (next_state == S_LOAD_FLG);
      o_busy     <= (next_state != S_IDLE);
      o_drop     <= valid_edge && (state != S_IDLE);
      o_leds     <= leds_for(next_state);
      if (state == S_IDLE && valid_edge) begin
        flg_q     <= i_flags;
        o_tx_data <= i_result;
      end else if (state == S_WAIT_RES && next_state == S_LOAD_FLG) begin
        o_tx_data <= flags_byte;
      end
    end
  end

endmodule
